// File: rtl/uart_rx_buffer_pkg.sv
// Shared definitions for the UART receive buffer: capture FSM encoding,
// entry layout and the parity-error helper.
package uart_rx_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } cap_state_t;

  localparam int ENTRY_W  = 9;
  localparam int DATA_MSB = 7;
  localparam int PERR_BIT = 8;

  // Even mode flags a set XOR over data+parity; odd mode flags a clear one.
  function automatic logic parity_err(input logic [ENTRY_W-1:0] sr, input logic odd);
    return (^sr) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_buffer_fifo.sv
// Parameterised synchronous FIFO with first-word fall-through read data;
// the read port holds the last popped word while empty.
module sync_fifo_param #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic [WIDTH-1:0]  r_last;

  logic              w_pop_ok;
  logic              w_push_ok;
  logic [ADDR_W:0]   w_count_next;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign w_pop_ok  = pop_i & ~r_empty;
  assign w_push_ok = push_i & (~r_full | w_pop_ok);

  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_last   <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_last   <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_FULL);
      r_empty <= (w_count_next == '0);
    end
  end

  assign rdata_o = r_empty ? r_last : r_mem[r_rd_ptr];
  assign full_o  = r_full;
  assign empty_o = r_empty;
  assign count_o = r_count;

endmodule

// File: rtl/uart_rx_buffer.sv
// Captures UART_Rx frames on rx_flag, checks parity, queues data+error in a
// FWFT FIFO and acknowledges each frame with a one-cycle rx_flag_clr pulse.
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_flag_i,
  input  logic [8:0]        rx_sr_i,
  output logic              rx_flag_clr_o,
  input  logic              rd_en_i,
  output logic [7:0]        rd_data_o,
  output logic              rd_perr_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overrun_o,
  input  logic              ovr_clr_i,
  output logic              irq_o
);

  cap_state_t         r_state;
  cap_state_t         w_state_next;
  logic               w_capture;
  logic               w_flag_clr;
  logic               w_perr;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] w_head;
  logic               r_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // WAIT holds until the receiver drops rx_flag so one frame is captured once.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_flag_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_flag_i) begin
          w_capture    = 1'b1;
          w_state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        w_flag_clr   = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!rx_flag_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_perr  = parity_err(rx_sr_i, PARITY_ODD != 0);
  assign w_entry = {w_perr, rx_sr_i[DATA_MSB:0]};
  // A full FIFO is never empty, so a same-cycle read always makes room.
  assign w_drop  = w_capture & w_full & ~rd_en_i;

  sync_fifo_param #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_capture),
    .wdata_i (w_entry),
    .pop_i   (rd_en_i),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (count_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr_i) begin
      r_overrun <= 1'b0;
    end
  end

  assign rx_flag_clr_o = w_flag_clr;
  assign rd_data_o     = w_head[DATA_MSB:0];
  assign rd_perr_o     = w_head[PERR_BIT];
  assign empty_o       = w_empty;
  assign full_o        = w_full;
  assign overrun_o     = r_overrun;
  assign irq_o         = ~w_empty;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: an even-parity and an odd-parity
// instance share stimulus; queued frames are compared as they are popped.
module tb_uart_rx_buffer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_flag = 1'b0;
  logic [8:0] rx_sr = '0;
  logic rd_en = 1'b0;
  logic ovr_clr = 1'b0;

  logic clr_e, perr_e, empty_e, full_e, ovr_e, irq_e;
  logic [7:0] data_e;
  logic [ADDR_W:0] count_e;
  logic clr_o, perr_o, empty_o, full_o, ovr_o, irq_o;
  logic [7:0] data_o;
  logic [ADDR_W:0] count_o;

  uart_rx_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PARITY_ODD(0)) u_dut_even (
    .clk(clk), .rst(rst), .rx_flag_i(rx_flag), .rx_sr_i(rx_sr), .rx_flag_clr_o(clr_e),
    .rd_en_i(rd_en), .rd_data_o(data_e), .rd_perr_o(perr_e), .empty_o(empty_e),
    .full_o(full_e), .count_o(count_e), .overrun_o(ovr_e), .ovr_clr_i(ovr_clr), .irq_o(irq_e)
  );

  uart_rx_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PARITY_ODD(1)) u_dut_odd (
    .clk(clk), .rst(rst), .rx_flag_i(rx_flag), .rx_sr_i(rx_sr), .rx_flag_clr_o(clr_o),
    .rd_en_i(rd_en), .rd_data_o(data_o), .rd_perr_o(perr_o), .empty_o(empty_o),
    .full_o(full_o), .count_o(count_o), .overrun_o(ovr_o), .ovr_clr_i(ovr_clr), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;
  logic [8:0] sb_q[$];
  int m_count = 0;
  logic m_ovr = 1'b0;
  logic [7:0] m_last = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic check_head(input string tag);
    chk({tag, ".data"}, 32'(data_e), 32'(sb_q[0][7:0]));
    chk({tag, ".data_odd"}, 32'(data_o), 32'(sb_q[0][7:0]));
    chk({tag, ".perr_even"}, 32'(perr_e), 32'(^sb_q[0]));
    chk({tag, ".perr_odd"}, 32'(perr_o), 32'(~^sb_q[0]));
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".count"}, 32'(count_e), 32'(m_count));
    chk({tag, ".count_odd"}, 32'(count_o), 32'(m_count));
    chk({tag, ".empty"}, 32'(empty_e), 32'(m_count == 0));
    chk({tag, ".full"}, 32'(full_e), 32'(m_count == DEPTH));
    chk({tag, ".irq"}, 32'(irq_e), 32'(m_count != 0));
    chk({tag, ".overrun"}, 32'(ovr_e), 32'(m_ovr));
    if (m_count > 0) check_head(tag);
    else chk({tag, ".held"}, 32'(data_e), 32'(m_last));
  endtask

  task automatic send_frame(input logic [8:0] sr, input logic pop, input logic clr);
    int pulses;
    logic accept;
    pulses = 0;
    @(negedge clk);
    rx_flag = 1'b1;
    rx_sr = sr;
    rd_en = pop;
    ovr_clr = clr;
    accept = (m_count < DEPTH) || (pop && m_count > 0);
    if (pop && m_count > 0) begin
      check_head("frame_pop");
      m_last = sb_q[0][7:0];
      void'(sb_q.pop_front());
      m_count--;
    end
    if (accept) begin
      sb_q.push_back(sr);
      m_count++;
    end
    if (!accept) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd_en = 1'b0;
      ovr_clr = 1'b0;
      if (clr_e) pulses++;
      if (i == 2) rx_flag = 1'b0;
    end
    $display("frame sr=%03h pop=%0b accepted=%0b count=%0d", sr, pop, accept, count_e);
    chk("clr_pulses", 32'(pulses), 32'd1);
    check_status("frame");
  endtask

  task automatic pop_one();
    @(negedge clk);
    if (m_count > 0) check_head("pop");
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (m_count > 0) begin
      m_last = sb_q[0][7:0];
      void'(sb_q.pop_front());
      m_count--;
    end
    $display("pop count=%0d data=%02h", count_e, data_e);
    check_status("pop");
  endtask

  task automatic clear_ovr();
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    m_ovr = 1'b0;
    $display("ovr_clr overrun=%0b", ovr_e);
    check_status("ovr_clr");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".clr"}, 32'(clr_e), 32'd0);
    chk({tag, ".data"}, 32'(data_e), 32'd0);
    chk({tag, ".perr"}, 32'(perr_e), 32'd0);
    chk({tag, ".perr_odd"}, 32'(perr_o), 32'd0);
    chk({tag, ".count"}, 32'(count_e), 32'd0);
    chk({tag, ".empty"}, 32'(empty_e), 32'd1);
    chk({tag, ".full"}, 32'(full_e), 32'd0);
    chk({tag, ".overrun"}, 32'(ovr_e), 32'd0);
    chk({tag, ".irq"}, 32'(irq_e), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    check_status("after_reset");

    send_frame(9'h0A5, 1'b0, 1'b0);
    pop_one();
    send_frame(9'h1A5, 1'b0, 1'b0);
    pop_one();

    for (int i = 0; i < DEPTH; i++) send_frame({1'b0, 8'(i)}, 1'b0, 1'b0);
    send_frame(9'h0FF, 1'b0, 1'b1);
    clear_ovr();

    send_frame(9'h008, 1'b1, 1'b0);

    repeat (DEPTH + 1) pop_one();
    send_frame(9'h110, 1'b1, 1'b0);
    send_frame(9'h011, 1'b0, 1'b0);
    send_frame(9'h112, 1'b0, 1'b0);
    repeat (3) pop_one();

    send_frame(9'h021, 1'b0, 1'b0);
    send_frame(9'h022, 1'b0, 1'b0);
    send_frame(9'h023, 1'b0, 1'b0);
    @(negedge clk);
    rx_flag = 1'b1;
    rx_sr = 9'h033;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    $display("reset asserted mid-frame count=%0d", count_e);
    check_reset_outputs("mid_reset");
    sb_q.delete();
    m_count = 0;
    m_ovr = 1'b0;
    m_last = '0;
    rx_flag = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send_frame(9'h044, 1'b0, 1'b0);
    pop_one();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
